// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder built on one full-adder cell.
// Operands are shifted out LSB first, one bit per clock, with a registered carry.
// SUM/Cout are registered and only updated when the last bit is produced.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             BUSY
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               ovalid_q, ovalid_d;

  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   acc_shift;

  // Full-adder cell on the current LSBs and the registered carry
  assign fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

  // New sum bit enters at the MSB; after WIDTH shifts the LSB lines up at bit 0
  assign acc_shift = WIDTH'({fa_sum, acc_q} >> 1);

  // State and datapath registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sum_q    <= sum_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovalid_q <= ovalid_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sum_d    = sum_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovalid_d = ovalid_q;

    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        acc_d   = acc_shift;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d    = acc_shift;
          cout_d   = fa_carry;
          ovalid_d = 1'b1;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake/status decode and registered result outputs
  assign IN_READY  = (state_q == IDLE);
  assign BUSY      = (state_q == ADD) || (state_q == HOLD);
  assign OUT_VALID = ovalid_q;
  assign SUM       = sum_q;
  assign Cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8, WIDTH=1 and WIDTH=4.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // WIDTH=8 instance
  logic       rst8, iv8, ir8, c8, ov8, or8, co8, bz8;
  logic [7:0] a8, b8, s8;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .CLK(clk), .RST(rst8), .IN_VALID(iv8), .IN_READY(ir8),
    .A(a8), .B(b8), .Cin(c8), .OUT_VALID(ov8), .OUT_READY(or8),
    .SUM(s8), .Cout(co8), .BUSY(bz8)
  );

  // WIDTH=1 instance
  logic rst1, iv1, ir1, c1, ov1, or1, co1, bz1;
  logic [0:0] a1, b1, s1;

  serial_adder #(.WIDTH(1)) u_dut1 (
    .CLK(clk), .RST(rst1), .IN_VALID(iv1), .IN_READY(ir1),
    .A(a1), .B(b1), .Cin(c1), .OUT_VALID(ov1), .OUT_READY(or1),
    .SUM(s1), .Cout(co1), .BUSY(bz1)
  );

  // WIDTH=4 instance
  logic       rst4, iv4, ir4, c4, ov4, or4, co4, bz4;
  logic [3:0] a4, b4, s4;

  serial_adder #(.WIDTH(4)) u_dut4 (
    .CLK(clk), .RST(rst4), .IN_VALID(iv4), .IN_READY(ir4),
    .A(a4), .B(b4), .Cin(c4), .OUT_VALID(ov4), .OUT_READY(or4),
    .SUM(s4), .Cout(co4), .BUSY(bz4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full WIDTH=8 operation with latency/status checks and an immediate drain
  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es, input logic ec);
    a8 = a; b8 = b; c8 = c; iv8 = 1'b1;
    check({name, " ready_before"}, 32'(ir8), 32'd1);
    tick;
    iv8 = 1'b0; a8 = ~a; b8 = ~b; c8 = ~c;
    check({name, " ov_after_accept"}, 32'(ov8), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick;
      check({name, " ov_latency"}, 32'(ov8), 32'(k == 8));
      check({name, " in_ready_busy"}, 32'(ir8), 32'd0);
      check({name, " busy"}, 32'(bz8), 32'd1);
    end
    check({name, " sum"}, 32'(s8), 32'(es));
    check({name, " cout"}, 32'(co8), 32'(ec));
    or8 = 1'b1;
    tick;
    or8 = 1'b0;
    check({name, " ov_drained"}, 32'(ov8), 32'd0);
    check({name, " ready_after"}, 32'(ir8), 32'd1);
    check({name, " idle_not_busy"}, 32'(bz8), 32'd0);
  endtask

  logic [1:0] e1;
  logic [4:0] e4;
  logic [4:0] sb4[$];
  int idx, n_in4, n_out4, cyc;
  logic ihs, ohs;

  initial begin
    rst8 = 1'b1; iv8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; or8 = 1'b0;
    rst1 = 1'b1; iv1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; or1 = 1'b0;
    rst4 = 1'b1; iv4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0; or4 = 1'b0;
    tick;
    rst8 = 1'b0; rst1 = 1'b0; rst4 = 1'b0;

    // Reset state
    check("rst in_ready", 32'(ir8), 32'd1);
    check("rst busy", 32'(bz8), 32'd0);
    check("rst out_valid", 32'(ov8), 32'd0);
    check("rst sum", 32'(s8), 32'd0);
    check("rst cout", 32'(co8), 32'd0);

    // Directed WIDTH=8 vectors
    run8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    run8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);
    run8("3c_42", 8'h3C, 8'h42, 1'b1, 8'h7F, 1'b0);

    // Backpressure with a competing request held on the input
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; iv8 = 1'b1;
    tick;
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
      end
      tick;
    end
    check("bp ov_rise", 32'(ov8), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp sum_stable", 32'(s8), 32'h46);
      check("bp cout_stable", 32'(co8), 32'd0);
      check("bp ov_stable", 32'(ov8), 32'd1);
      check("bp no_accept", 32'(ir8), 32'd0);
      tick;
    end
    or8 = 1'b1;
    tick;
    or8 = 1'b0;
    check("bp released ov", 32'(ov8), 32'd0);
    check("bp released ready", 32'(ir8), 32'd1);
    tick;
    iv8 = 1'b0;
    check("bp second accepted", 32'(ir8), 32'd0);
    check("bp second busy", 32'(bz8), 32'd1);
    repeat (8) tick;
    check("bp second ov", 32'(ov8), 32'd1);
    check("bp second sum", 32'(s8), 32'h02);
    check("bp second cout", 32'(co8), 32'd0);
    or8 = 1'b1;
    tick;
    or8 = 1'b0;

    // Reset in the middle of ADD aborts the operation
    a8 = 8'hF0; b8 = 8'h0F; c8 = 1'b0; iv8 = 1'b1;
    tick;
    iv8 = 1'b0;
    repeat (3) tick;
    rst8 = 1'b1;
    tick;
    rst8 = 1'b0;
    check("abort ov", 32'(ov8), 32'd0);
    check("abort ready", 32'(ir8), 32'd1);
    check("abort busy", 32'(bz8), 32'd0);
    check("abort sum", 32'(s8), 32'd0);
    check("abort cout", 32'(co8), 32'd0);
    for (int k = 0; k < 10; k++) begin
      tick;
      check("abort no_result", 32'(ov8), 32'd0);
    end

    // WIDTH=1: all eight input combinations
    for (int k = 0; k < 8; k++) begin
      {a1, b1, c1} = 3'(k);
      e1 = 2'(a1) + 2'(b1) + 2'(c1);
      iv1 = 1'b1;
      check("w1 ready", 32'(ir1), 32'd1);
      tick;
      iv1 = 1'b0;
      check("w1 ov_after_accept", 32'(ov1), 32'd0);
      tick;
      check("w1 ov_rise", 32'(ov1), 32'd1);
      check("w1 result", 32'({co1, s1}), 32'(e1));
      or1 = 1'b1;
      tick;
      or1 = 1'b0;
    end

    // WIDTH=4: all 512 combinations back-to-back with random output stalls
    idx = 0; n_in4 = 0; n_out4 = 0; cyc = 0;
    while (n_out4 < 512 && cyc < 20000) begin
      iv4 = (idx < 512);
      a4  = 4'(idx >> 5);
      b4  = 4'(idx >> 1);
      c4  = 1'(idx);
      or4 = ($urandom_range(0, 3) != 0);
      ihs = iv4 && ir4;
      ohs = ov4 && or4;
      if (ohs) begin
        check("w4 out_has_input", 32'(sb4.size() != 0), 32'd1);
        if (sb4.size() != 0) begin
          e4 = sb4.pop_front();
          check("w4 result", 32'({co4, s4}), 32'(e4));
        end
        n_out4++;
      end
      if (ihs) begin
        sb4.push_back(5'(a4) + 5'(b4) + 5'(c4));
        idx++;
        n_in4++;
      end
      tick;
      cyc++;
    end
    iv4 = 1'b0; or4 = 1'b0;
    check("w4 in_count", 32'(n_in4), 32'd512);
    check("w4 out_count", 32'(n_out4), 32'd512);
    check("w4 scoreboard_empty", 32'(sb4.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, multi-bit adder built around a single 1-bit full-adder cell (SUM = a^b^c, carry = majority(a,b,c)) plus a registered carry.
- Adds two WIDTH-bit operands and a carry-in, LSB first, one bit per clock.
- Sits as the sequential stage wrapping the team's combinational full-adder cell, trading area for latency.
- Valid/ready handshakes on input and output. One operation in flight at a time.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range is WIDTH >= 1.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge. Design has one clock.
- RST  input  1  reset, synchronous and active-high.
- IN_VALID  input  1  operands A, B, Cin are valid.
- IN_READY  output  1  block can accept operands; high only in IDLE.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in.
- OUT_VALID  output  1  SUM/Cout hold a completed result.
- OUT_READY  input  1  consumer accepts the result.
- SUM  output  WIDTH  registered result, equal to (A+B+Cin) mod 2^WIDTH.
- Cout  output  1  registered carry-out, bit WIDTH of A+B+Cin.
- BUSY  output  1  high in ADD or HOLD.

Behaviour:
- Reset (RST=1 at a rising edge):
  - state <= IDLE; operand shift registers, carry register, bit counter, SUM and Cout all <= 0; OUT_VALID <= 0.
  - After that edge, IN_READY=1 and BUSY=0.
  - Reset in any state aborts the operation; no result is produced.
  - Reset has priority over every other event in the same cycle.
- IDLE:
  - IN_READY=1.
  - On an edge with IN_VALID=1: a_sr <= A, b_sr <= B, carry <= Cin, count <= 0, state <= ADD.
  - SUM and Cout keep their previous values.
- ADD:
  - Each edge, the full-adder cell takes a_sr[0], b_sr[0] and carry.
  - Its sum bit is shifted into the MSB of an internal accumulator, which shifts right.
  - a_sr and b_sr shift right by 1, carry <= cell carry-out, count <= count+1.
  - IN_VALID is ignored. A, B and Cin may change freely after acceptance without affecting the result.
  - On the edge where count == WIDTH-1:
    - SUM <= completed accumulator value, including the bit just produced.
    - Cout <= cell carry-out.
    - OUT_VALID <= 1, state <= HOLD.
  - SUM and Cout are not updated on any earlier ADD edge.
- HOLD:
  - OUT_VALID=1; SUM and Cout stay stable for as long as OUT_READY=0, with no bound on the wait.
  - On an edge with OUT_READY=1: OUT_VALID <= 0, state <= IDLE.
  - IN_READY=0 throughout HOLD, so a new operation cannot be accepted in the same cycle as the output handshake.
- Latency and throughput:
  - Acceptance edge E0; OUT_VALID rises at edge E0+WIDTH.
  - Minimum spacing between acceptances is WIDTH+2 edges (WIDTH ADD edges, one HOLD cycle with OUT_READY=1, one IDLE cycle).
- WIDTH=1: exactly one ADD edge; OUT_VALID rises one edge after acceptance.
- Counter width: $clog2(WIDTH+1) bits, with no wrap during a legal operation.
- Outputs are all registered, except IN_READY and BUSY, which are decoded from state.

Test Plan:
- Reset, then A=8'h00, B=8'h00, Cin=0 accepted at edge E0 -> OUT_VALID first high after edge E0+8; SUM=8'h00, Cout=0; IN_READY=0 and BUSY=1 during edges E1..E8.
- A=8'hFF, B=8'h01, Cin=0 -> SUM=8'h00, Cout=1. Then A=8'hA5, B=8'h5A, Cin=1 -> SUM=8'h00, Cout=1. Then A=8'h3C, B=8'h42, Cin=1 -> SUM=8'h7F, Cout=0.
- Backpressure and overlap:
  - Stimulus: result ready for A=8'h12, B=8'h34, Cin=0; hold OUT_READY=0 for 5 cycles; meanwhile drive IN_VALID=1 with A=8'h01, B=8'h01, Cin=0, and change A/B during ADD.
  - Required: SUM=8'h46 and Cout=0 stable for all 5 cycles; the new operands are not accepted while IN_READY=0.
  - Release OUT_READY -> one IDLE cycle, then 8'h01+8'h01 is accepted and gives SUM=8'h02.
- Assert RST at the 4th ADD edge of A=8'hF0, B=8'h0F -> following cycle OUT_VALID=0, IN_READY=1, SUM=8'h00, Cout=0; no OUT_VALID for at least 10 cycles with IN_VALID=0.
- WIDTH=1: run all 8 combinations of A, B, Cin -> {Cout,SUM} = A+B+Cin, with OUT_VALID rising one edge after acceptance.
- WIDTH=4: run all 512 combinations of A, B, Cin back-to-back with random OUT_READY stalls -> every {Cout,SUM} matches a scoreboard of A+B+Cin, and exactly one output handshake occurs per input handshake.
